// File: rtl/fsqrt_arb_pkg.sv
// Shared types and constants for the fsqrt arbiter and its response FIFOs.
package fsqrt_arb_pkg;

  localparam int FP_W           = 32;
  localparam int NREQ_DEF       = 4;
  localparam int FSQRT_LAT_DEF  = 3;
  localparam int RESP_DEPTH_DEF = 2;

  // Tag id field is sized for the largest supported requester count (8).
  localparam int TAG_IDW = 3;

  typedef struct packed {
    logic               v;
    logic [TAG_IDW-1:0] id;
  } tag_t;

  // Result the fsqrt unit returns for a negative operand.
  localparam logic [FP_W-1:0] FSQRT_NAN = 32'h7FFF_FFFF;

endpackage

// File: rtl/fsqrt_resp_fifo.sv
// Per-requester response FIFO: DEPTH entries of FP_W bits, head shown
// combinationally, zero on the output while empty.
module fsqrt_resp_fifo
  import fsqrt_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_push,
  input  logic [FP_W-1:0] i_data,
  input  logic            i_pop,
  output logic [FP_W-1:0] o_data,
  output logic            o_full,
  output logic            o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [FP_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_cnt;
  logic            w_do_push;
  logic            w_do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_cnt == '0);
  assign o_full    = (r_cnt == CW'(DEPTH));
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_next(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage write; contents are meaningless until counted in by r_cnt.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/fsqrt_arbiter.sv
// Round-robin, credit-gated sharing of one fixed-latency fsqrt unit between
// NREQ requesters, with per-requester in-order response FIFOs.
module fsqrt_arbiter
  import fsqrt_arb_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int FSQRT_LAT  = FSQRT_LAT_DEF,
  parameter int RESP_DEPTH = RESP_DEPTH_DEF,
  parameter int IDW        = $clog2(NREQ)
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*FP_W-1:0] req_x,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      resp_valid,
  output logic [NREQ*FP_W-1:0] resp_y,
  input  logic [NREQ-1:0]      resp_ready,
  output logic                 fu_valid,
  output logic [FP_W-1:0]      fu_x,
  input  logic [FP_W-1:0]      fu_y,
  input  logic                 fu_out_valid,
  output logic                 err
);

  localparam int CW       = $clog2(RESP_DEPTH + 1);
  localparam int MASK_CYC = FSQRT_LAT + 1;
  localparam int MW       = $clog2(MASK_CYC + 1);

  logic [IDW-1:0]  r_rr_ptr;
  logic [CW-1:0]   r_credit [NREQ];
  logic            r_fu_valid;
  logic [FP_W-1:0] r_fu_x;
  tag_t            r_tag [FSQRT_LAT+1];
  logic [MW-1:0]   r_mask_cnt;
  logic            r_err;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic            w_gnt_any;
  logic [IDW-1:0]  w_gnt_id;
  logic [NREQ-1:0] w_push;
  logic [NREQ-1:0] w_pop;
  logic [NREQ-1:0] w_empty;
  logic [NREQ-1:0] w_full;
  logic            w_mask;

  // Requester index k positions after ptr, wrapping at NREQ.
  function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] ptr, input int k);
    int s;
    s = int'(ptr) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  assign req_ready = w_gnt;
  assign fu_valid  = r_fu_valid;
  assign fu_x      = r_fu_x;
  assign err       = r_err;
  assign w_mask    = (r_mask_cnt < MW'(MASK_CYC));

  // Round-robin pick of the first eligible requester at or after r_rr_ptr.
  always_comb begin
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_id  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req_valid[i] && (r_credit[i] != '0);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_any && w_elig[rr_idx(r_rr_ptr, k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_id  = rr_idx(r_rr_ptr, k);
      end
    end
    if (w_gnt_any) w_gnt[w_gnt_id] = 1'b1;
  end

  // Pointer advance, issue register and tag pipeline aligned with the unit.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr   <= '0;
      r_fu_valid <= 1'b0;
      r_fu_x     <= '0;
      for (int j = 0; j <= FSQRT_LAT; j++) r_tag[j] <= '0;
    end else begin
      r_fu_valid <= w_gnt_any;
      r_tag[0]   <= '{v: w_gnt_any, id: TAG_IDW'(w_gnt_id)};
      for (int j = 1; j <= FSQRT_LAT; j++) r_tag[j] <= r_tag[j-1];
      if (w_gnt_any) begin
        r_rr_ptr <= rr_idx(w_gnt_id, 1);
        r_fu_x   <= req_x[int'(w_gnt_id)*FP_W +: FP_W];
      end
    end
  end

  // Credits: one per free response slot; taken on grant, returned on pop.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREQ; i++) r_credit[i] <= CW'(RESP_DEPTH);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        case ({w_gnt[i], w_pop[i]})
          2'b10:   r_credit[i] <= r_credit[i] - 1'b1;
          2'b01:   r_credit[i] <= r_credit[i] + 1'b1;
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  // Sticky mismatch between expected and reported unit output, ignoring the
  // window after reset where the unreset unit may still emit stale results.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_mask_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_mask) r_mask_cnt <= r_mask_cnt + 1'b1;
      if (!w_mask && (r_tag[FSQRT_LAT].v != fu_out_valid)) r_err <= 1'b1;
    end
  end

  // Credits must keep every retiring result from landing in a full FIFO.
  always @(posedge sys_clk) begin
    if (rst) assert (!(|(w_push & w_full)));
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_resp
    assign w_push[gi]     = r_tag[FSQRT_LAT].v && (r_tag[FSQRT_LAT].id == TAG_IDW'(gi));
    assign w_pop[gi]      = resp_ready[gi] && !w_empty[gi];
    assign resp_valid[gi] = !w_empty[gi];

    fsqrt_resp_fifo #(
      .DEPTH (RESP_DEPTH)
    ) u_fifo (
      .i_clk   (sys_clk),
      .i_rst_n (rst),
      .i_push  (w_push[gi]),
      .i_data  (fu_y),
      .i_pop   (w_pop[gi]),
      .o_data  (resp_y[gi*FP_W +: FP_W]),
      .o_full  (w_full[gi]),
      .o_empty (w_empty[gi])
    );
  end

endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Directed bench for fsqrt_arbiter with a behavioural fixed-latency fsqrt unit.
module tb_fsqrt_arbiter;
  import fsqrt_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int LAT   = 3;
  localparam int DEPTH = 2;

  logic              sys_clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*32-1:0] req_x = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [NREQ*32-1:0] resp_y;
  logic [NREQ-1:0]   resp_ready = '0;
  logic              fu_valid;
  logic [31:0]       fu_x;
  logic [31:0]       fu_y;
  logic              fu_out_valid;
  logic              err;

  // Behavioural fsqrt unit: not reset, fixed LAT-cycle latency.
  logic [LAT:1]      pv = '0;
  logic [31:0]       px [1:LAT] = '{default: 32'h0};
  logic              force_ov = 1'b0;

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] opnd  [4][2];
  logic [31:0] exp_y [4][2];
  int          cnt   [4];
  int          rcnt  [4];

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] fake_sqrt(input logic [31:0] x);
    if (x[31]) return FSQRT_NAN;
    case (x)
      32'h3F80_0000: return 32'h3F80_0000;
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      32'h4180_0000: return 32'h4080_0000;
      32'h41C8_0000: return 32'h40A0_0000;
      32'h4210_0000: return 32'h40C0_0000;
      32'h4244_0000: return 32'h40E0_0000;
      32'h4280_0000: return 32'h4100_0000;
      default:       return 32'h0;
    endcase
  endfunction

  always @(posedge sys_clk) begin
    pv <= {pv[LAT-1:1], fu_valid};
    for (int j = LAT; j >= 2; j--) px[j] <= px[j-1];
    px[1] <= fu_x;
  end

  assign fu_out_valid = pv[LAT] | force_ov;
  assign fu_y         = fake_sqrt(px[LAT]);

  fsqrt_arbiter #(
    .NREQ       (NREQ),
    .FSQRT_LAT  (LAT),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .sys_clk      (sys_clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_x        (req_x),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_y       (resp_y),
    .resp_ready   (resp_ready),
    .fu_valid     (fu_valid),
    .fu_x         (fu_x),
    .fu_y         (fu_y),
    .fu_out_valid (fu_out_valid),
    .err          (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  initial begin
    opnd[0][0] = 32'h4080_0000; opnd[0][1] = 32'h4180_0000;
    opnd[1][0] = 32'h4110_0000; opnd[1][1] = 32'h41C8_0000;
    opnd[2][0] = 32'h4210_0000; opnd[2][1] = 32'h3F80_0000;
    opnd[3][0] = 32'h4244_0000; opnd[3][1] = 32'h4280_0000;
    exp_y[0][0] = 32'h4000_0000; exp_y[0][1] = 32'h4080_0000;
    exp_y[1][0] = 32'h4040_0000; exp_y[1][1] = 32'h40A0_0000;
    exp_y[2][0] = 32'h40C0_0000; exp_y[2][1] = 32'h3F80_0000;
    exp_y[3][0] = 32'h40E0_0000; exp_y[3][1] = 32'h4100_0000;

    // Reset state
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_resp_y0", resp_y[31:0], 32'h0);
    chk("rst_fu_valid", 32'(fu_valid), 32'h0);
    chk("rst_fu_x", fu_x, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("post_rst_err", 32'(err), 32'h0);

    // Single op from requester 0
    req_x[31:0] = 32'h4080_0000;
    req_valid   = 4'b0001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_fu_valid_pre", 32'(fu_valid), 32'h0);
    tick();
    req_valid = 4'b0000;
    #1;
    chk("t1_fu_valid", 32'(fu_valid), 32'h1);
    chk("t1_fu_x", fu_x, 32'h4080_0000);
    chk("t1_ready_off", 32'(req_ready), 32'h0);
    tick();
    #1;
    chk("t1_fu_valid_off", 32'(fu_valid), 32'h0);
    tick();
    tick();
    #1;
    chk("t1_resp_early", 32'(resp_valid), 32'h0);
    tick();
    #1;
    chk("t1_resp_valid", 32'(resp_valid), 32'h1);
    chk("t1_resp_y", resp_y[31:0], 32'h4000_0000);
    resp_ready = 4'b1111;
    tick();
    #1;
    chk("t1_resp_popped", 32'(resp_valid), 32'h0);

    // Negative operand from requester 1
    req_x[63:32] = 32'hBF80_0000;
    req_valid    = 4'b0010;
    #1;
    chk("neg_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    repeat (4) tick();
    #1;
    chk("neg_resp_valid", 32'(resp_valid), 32'h2);
    chk("neg_resp_y", resp_y[63:32], FSQRT_NAN);
    tick();
    #1;
    chk("neg_resp_popped", 32'(resp_valid), 32'h0);

    // Reset with three operations in flight
    req_x     = {4{32'h4080_0000}};
    req_valid = 4'b0111;
    #1;
    chk("mid_gnt_a", 32'(req_ready), 32'h4);
    tick();
    #1;
    chk("mid_gnt_b", 32'(req_ready), 32'h1);
    tick();
    #1;
    chk("mid_gnt_c", 32'(req_ready), 32'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    chk("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
    for (int i = 0; i < NREQ; i++) chk("mid_rst_resp_y", resp_y[i*32 +: 32], 32'h0);
    chk("mid_rst_fu_valid", 32'(fu_valid), 32'h0);
    chk("mid_rst_fu_x", fu_x, 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      #1;
      chk("mid_no_resp", 32'(resp_valid), 32'h0);
      chk("mid_no_err", 32'(err), 32'h0);
    end

    // All four requesters continuously valid
    for (int i = 0; i < 4; i++) begin
      cnt[i]  = 0;
      rcnt[i] = 0;
    end
    for (int c = 0; c < 16; c++) begin
      for (int i = 0; i < 4; i++) begin
        req_valid[i]     = (cnt[i] < 2);
        req_x[i*32 +: 32] = opnd[i][(cnt[i] < 2) ? cnt[i] : 1];
      end
      #1;
      chk("all4_ready", 32'(req_ready), (c < 8) ? (32'd1 << (c % 4)) : 32'd0);
      if (c >= 1 && c <= 8) chk("all4_fu_valid", 32'(fu_valid), 32'h1);
      for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
      for (int i = 0; i < 4; i++) begin
        if (resp_valid[i]) begin
          chk("all4_resp_y", resp_y[i*32 +: 32], exp_y[i][(rcnt[i] < 2) ? rcnt[i] : 1]);
          rcnt[i]++;
        end
      end
      tick();
    end
    req_valid = 4'b0000;
    for (int i = 0; i < 4; i++) chk("all4_resp_count", 32'(rcnt[i]), 32'd2);

    // Backpressure on requester 2
    resp_ready    = 4'b1011;
    req_valid     = 4'b0100;
    req_x[95:64]  = 32'h4180_0000;
    #1;
    chk("bp_accept_1", 32'(req_ready), 32'h4);
    tick();
    req_x[95:64] = 32'h4110_0000;
    #1;
    chk("bp_accept_2", 32'(req_ready), 32'h4);
    tick();
    req_x[95:64] = 32'h3F80_0000;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("bp_blocked", 32'(req_ready), 32'h0);
      tick();
    end
    #1;
    chk("bp_resp_valid", 32'(resp_valid), 32'h4);
    chk("bp_head_1", resp_y[95:64], 32'h4080_0000);
    resp_ready = 4'b1111;
    chk("bp_pop_cycle_ready", 32'(req_ready), 32'h0);
    tick();
    resp_ready = 4'b1011;
    #1;
    chk("bp_accept_3", 32'(req_ready), 32'h4);
    chk("bp_head_2", resp_y[95:64], 32'h4040_0000);
    tick();
    #1;
    chk("bp_blocked_again", 32'(req_ready), 32'h0);
    req_valid  = 4'b0000;
    resp_ready = 4'b1111;
    repeat (10) tick();
    #1;
    chk("bp_drained", 32'(resp_valid), 32'h0);
    chk("bp_no_err", 32'(err), 32'h0);

    // Spurious unit output after the mask window
    force_ov = 1'b1;
    #1;
    chk("fault_err_before", 32'(err), 32'h0);
    tick();
    force_ov = 1'b0;
    #1;
    chk("fault_err_set", 32'(err), 32'h1);
    repeat (3) tick();
    #1;
    chk("fault_err_sticky", 32'(err), 32'h1);
    rst = 1'b0;
    #1;
    chk("fault_err_cleared", 32'(err), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
